// File: rtl/program_loader_if.sv
// Byte-stream input and memory write port of the program loader.
interface program_loader_if;
    logic        byte_valid;
    logic [7:0]  byte_data;
    logic        byte_ready;
    logic [31:0] Address;
    logic [31:0] Write_data;
    logic        MemWrite;

    // master feeds program bytes and observes the memory port; slave is the loader.
    modport master (output byte_valid, byte_data,
                    input  byte_ready, Address, Write_data, MemWrite);
    modport slave  (input  byte_valid, byte_data,
                    output byte_ready, Address, Write_data, MemWrite);
endinterface

// File: rtl/program_loader.sv
// Loads a length-prefixed serial byte stream into word memory, big-endian,
// holding the CPU until the last word has been written.
module program_loader #(
    parameter int RAM_SIZE     = 256,
    parameter int RAM_SIZE_BIT = 8,
    parameter int BASE_WORD    = 0
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    program_loader_if.slave bus,
    output logic            cpu_hold,
    output logic            done,
    output logic [7:0]      word_count
);
    typedef enum logic [2:0] {IDLE, HDR, DATA, WRITE, DONE} state_t;

    state_t                  state, state_next;
    logic [7:0]              word_idx;
    logic [1:0]              byte_cnt;
    logic [31:0]             addr_q;
    logic [31:0]             wdata_q;
    logic                    ready;
    logic                    accept;
    logic                    mem_write;
    logic                    last_word;
    logic [RAM_SIZE_BIT-1:0] ram_idx;

    assign ready     = (state == HDR) || (state == DATA);
    assign accept    = bus.byte_valid && ready;
    assign last_word = (word_idx + 8'd1) == word_count;
    // Word slot wraps around the end of memory when BASE_WORD is near the top.
    assign ram_idx   = RAM_SIZE_BIT'((32'(word_idx) + 32'(BASE_WORD)) % 32'(RAM_SIZE));

    // NOTE: registers use non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_next;
    end

    // NOTE: every output is defaulted first so no path through the case infers a latch.
    always_comb begin
        state_next = state;
        cpu_hold   = 1'b0;
        done       = 1'b0;
        mem_write  = 1'b0;
        case (state)
            IDLE: if (start) state_next = HDR;
            HDR: begin
                cpu_hold = 1'b1;
                if (bus.byte_valid) state_next = (bus.byte_data == 8'd0) ? DONE : DATA;
            end
            DATA: begin
                cpu_hold = 1'b1;
                if (bus.byte_valid && byte_cnt == 2'd3) state_next = WRITE;
            end
            WRITE: begin
                cpu_hold   = 1'b1;
                mem_write  = 1'b1;
                state_next = last_word ? DONE : DATA;
            end
            DONE: begin
                done = 1'b1;
                if (start) state_next = HDR;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            word_idx   <= '0;
            byte_cnt   <= '0;
            word_count <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
        end else begin
            case (state)
                IDLE, DONE: if (start) begin
                    word_idx <= '0;
                    byte_cnt <= '0;
                end
                HDR: if (accept) word_count <= bus.byte_data;
                DATA: if (accept) begin
                    wdata_q  <= {wdata_q[23:0], bus.byte_data};
                    byte_cnt <= byte_cnt + 2'd1;
                    // Address is latched as the word completes so it is steady through WRITE.
                    if (byte_cnt == 2'd3) addr_q <= 32'({ram_idx, 2'b00});
                end
                WRITE: begin
                    word_idx <= word_idx + 8'd1;
                    byte_cnt <= '0;
                end
                default: ;
            endcase
        end
    end

    assign bus.byte_ready = ready;
    assign bus.Address    = addr_q;
    assign bus.Write_data = wdata_q;
    assign bus.MemWrite   = mem_write;
endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader: two instances (BASE_WORD 0 and 254)
// share one stimulus stream; a monitor logs every memory write.
module tb_program_loader;
    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic       byte_valid;
    logic [7:0] byte_data;
    logic       cpu_hold0, done0, cpu_hold1, done1;
    logic [7:0] wc0, wc1;

    program_loader_if bus0 ();
    program_loader_if bus1 ();

    assign bus0.byte_valid = byte_valid;
    assign bus0.byte_data  = byte_data;
    assign bus1.byte_valid = byte_valid;
    assign bus1.byte_data  = byte_data;

    program_loader #(.RAM_SIZE(256), .RAM_SIZE_BIT(8), .BASE_WORD(0)) dut0 (
        .clk(clk), .reset(reset), .start(start), .bus(bus0),
        .cpu_hold(cpu_hold0), .done(done0), .word_count(wc0));

    program_loader #(.RAM_SIZE(256), .RAM_SIZE_BIT(8), .BASE_WORD(254)) dut1 (
        .clk(clk), .reset(reset), .start(start), .bus(bus1),
        .cpu_hold(cpu_hold1), .done(done1), .word_count(wc1));

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    int          cycle = 0;
    int          long_pulse = 0;
    logic        mw_prev = 1'b0;
    logic [31:0] wa0[$];
    logic [31:0] wd0[$];
    logic [31:0] wa1[$];
    int          wcyc[$];

    always @(posedge clk) cycle <= cycle + 1;

    always @(negedge clk) begin
        if (bus0.MemWrite) begin
            wa0.push_back(bus0.Address);
            wd0.push_back(bus0.Write_data);
            wcyc.push_back(cycle);
            if (mw_prev) long_pulse <= long_pulse + 1;
        end
        if (bus1.MemWrite) wa1.push_back(bus1.Address);
        mw_prev <= bus0.MemWrite;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic clear_log();
        wa0.delete();
        wd0.delete();
        wa1.delete();
        wcyc.delete();
    endtask

    task automatic start_load();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Presents one byte and returns on the negedge after it was taken.
    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        byte_valid = 1'b1;
        byte_data  = b;
        while (!bus0.byte_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        check($sformatf("accept_%02h", b), 32'(bus0.byte_ready), 32'd1);
        @(negedge clk);
        byte_valid = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [7:0] a_bytes[8] = '{8'h08, 8'h04, 8'h00, 8'h05, 8'h20, 8'h00, 8'h00, 8'h08};
        logic [7:0] c_bytes[4] = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};

        reset = 1'b1; start = 1'b0; byte_valid = 1'b0; byte_data = 8'h00;
        #2 reset = 1'b0;
        @(negedge clk);
        check("rst_ready",    32'(bus0.byte_ready), 0);
        check("rst_memwrite", 32'(bus0.MemWrite), 0);
        check("rst_hold",     32'(cpu_hold0), 0);
        check("rst_done",     32'(done0), 0);
        check("rst_addr",     bus0.Address, 0);
        check("rst_addr_b254", bus1.Address, 0);
        check("rst_wdata",    bus0.Write_data, 0);
        check("rst_wcount",   32'(wc0), 0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("idle_hold",  32'(cpu_hold0), 0);
        check("idle_ready", 32'(bus0.byte_ready), 0);

        // Two words at full rate.
        clear_log();
        start_load();
        check("A_hdr_hold",  32'(cpu_hold0), 1);
        check("A_hdr_ready", 32'(bus0.byte_ready), 1);
        check("A_hdr_done",  32'(done0), 0);
        send_byte(8'h02);
        foreach (a_bytes[i]) send_byte(a_bytes[i]);
        @(negedge clk);
        check("A_nwrites",  32'(wa0.size()), 2);
        check("A_addr0",    wa0[0], 32'h0);
        check("A_data0",    wd0[0], 32'h08040005);
        check("A_addr1",    wa0[1], 32'h4);
        check("A_data1",    wd0[1], 32'h20000008);
        check("A_period",   32'(wcyc[1] - wcyc[0]), 5);
        check("A_b254_a0",  wa1[0], 32'h3F8);
        check("A_b254_a1",  wa1[1], 32'h3FC);
        check("A_done",     32'(done0), 1);
        check("A_hold_off", 32'(cpu_hold0), 0);
        check("A_wcount",   32'(wc0), 2);

        // Empty program.
        clear_log();
        start_load();
        check("B_done_clr", 32'(done0), 0);
        send_byte(8'h00);
        check("B_done",    32'(done0), 1);
        check("B_hold",    32'(cpu_hold0), 0);
        check("B_wcount",  32'(wc0), 0);
        check("B_nwrites", 32'(wa0.size()), 0);

        // One word with byte_valid toggling every cycle.
        clear_log();
        start_load();
        send_byte(8'h01);
        for (int i = 0; i < 4; i++) begin
            send_byte(c_bytes[i]);
            if (i < 3) begin
                @(negedge clk);
                check("C_gap_addr", bus0.Address, 32'h4);
                check("C_gap_hold", 32'(cpu_hold0), 1);
            end
        end
        check("C_we",   32'(bus0.MemWrite), 1);
        check("C_addr", bus0.Address, 32'h0);
        @(negedge clk);
        check("C_nwrites", 32'(wa0.size()), 1);
        check("C_data",    wd0[0], 32'hDEADBEEF);
        check("C_done",    32'(done0), 1);

        // start held high for a whole load, then immediate restart from DONE.
        clear_log();
        start = 1'b1;
        @(negedge clk);
        send_byte(8'h01);
        send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
        check("D_we",   32'(bus0.MemWrite), 1);
        check("D_hold", 32'(cpu_hold0), 1);
        @(negedge clk);
        check("D_done", 32'(done0), 1);
        @(negedge clk);
        check("D_rehdr_done",  32'(done0), 0);
        check("D_rehdr_ready", 32'(bus0.byte_ready), 1);
        start = 1'b0;
        check("D_nwrites", 32'(wa0.size()), 1);
        check("D_addr",    wa0[0], 32'h0);
        check("D_data",    wd0[0], 32'h11223344);

        // Reset with half a word assembled, then a clean single-word load.
        send_byte(8'h03);
        send_byte(8'hAA);
        send_byte(8'hBB);
        reset = 1'b0;
        #1;
        check("E_rst_we",    32'(bus0.MemWrite), 0);
        check("E_rst_hold",  32'(cpu_hold0), 0);
        check("E_rst_ready", 32'(bus0.byte_ready), 0);
        check("E_rst_wdata", bus0.Write_data, 0);
        check("E_rst_wcnt",  32'(wc0), 0);
        @(negedge clk);
        reset = 1'b1;
        clear_log();
        start_load();
        send_byte(8'h01);
        send_byte(8'h5A); send_byte(8'h5B); send_byte(8'h5C); send_byte(8'h5D);
        @(negedge clk);
        check("E_nwrites", 32'(wa0.size()), 1);
        check("E_addr",    wa0[0], 32'h0);
        check("E_data",    wd0[0], 32'h5A5B5C5D);
        check("E_b254_a0", wa1[0], 32'h3F8);

        // Reset while in WRITE drops the strobe at once; nothing moves without start.
        start_load();
        send_byte(8'h02);
        send_byte(8'hC0); send_byte(8'hC1); send_byte(8'hC2); send_byte(8'hC3);
        check("F_we", 32'(bus0.MemWrite), 1);
        reset = 1'b0;
        #1;
        check("F_rst_we",   32'(bus0.MemWrite), 0);
        check("F_rst_hold", 32'(cpu_hold0), 0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("F_idle_hold", 32'(cpu_hold0), 0);
        check("F_idle_done", 32'(done0), 0);

        // Three words: BASE_WORD 254 wraps past the top of memory.
        clear_log();
        start_load();
        send_byte(8'h03);
        for (int i = 1; i <= 12; i++) send_byte(8'(i));
        @(negedge clk);
        check("G_nwrites", 32'(wa0.size()), 3);
        check("G_addr2",   wa0[2], 32'h8);
        check("G_data2",   wd0[2], 32'h090A0B0C);
        check("G_period",  32'(wcyc[2] - wcyc[1]), 5);
        check("G_b254_a0", wa1[0], 32'h3F8);
        check("G_b254_a1", wa1[1], 32'h3FC);
        check("G_b254_a2", wa1[2], 32'h000);
        check("G_done",    32'(done1), 1);

        check("single_cycle_we", 32'(long_pulse), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
